// File: rtl/wb_data_ram_pkg.sv
// Shared types and constants for the Wishbone data RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_data_ram_pkg;

    // Bus widths, matching the CPU's 32-bit register bus.
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;   // wait-state counter, covers 0..15

    // Big-endian lane mapping: byte offset 0 sits in the top byte of the word.
    localparam int LANE_B0 = 3;
    localparam int LANE_B1 = 2;
    localparam int LANE_B2 = 1;
    localparam int LANE_B3 = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/wb_data_ram_byte_bank.sv
// One byte lane of the data RAM: 2**ADDR_W x 8 single-port synchronous memory.
// Latency: write and read both take effect on the clock edge where we/re is high.
// Backpressure: none; the controller issues at most one access per cycle.
//
// Ports: clk, rst (clears only the read register), we/re strobes, addr word
// index, din write byte, dout registered read byte.
module byte_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // Storage is not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // The read register doubles as the bus read-data holding register, so it
    // clears on reset and otherwise keeps its value until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
        end else if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone-classic slave data RAM with byte-lane writes and WAIT_STATES wait cycles.
// Latency: ack in cycle T+1+WAIT_STATES after acceptance in cycle T; one transfer per WAIT_STATES+2 cycles.
// Backpressure: requests are held off (no ack) until the FSM returns to IDLE; cyc drop during WAIT aborts.
//
// Ports: clk, rst (sync, active-high); wb_cyc_i/wb_stb_i request, wb_we_i direction,
// wb_adr_i byte address (word index in [ADDR_W+1:2]), wb_sel_i big-endian lane enables,
// wb_dat_i write data; wb_dat_o read data (held until next read ack), wb_ack_o one-cycle ack.
module wb_data_ram
    import wb_data_ram_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o
);

    // Final WAIT cycle index; WAIT is unreachable when WAIT_STATES is 0.
    localparam logic [CNT_W-1:0] WS_LAST =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept;
    logic              commit;

    // Request captured at acceptance.
    logic [ADDR_W-1:0] adr_q;
    logic [SEL_W-1:0]  sel_q;
    logic              we_q;
    logic [DATA_W-1:0] dat_q;

    // Access presented to the banks on the commit edge.
    logic [ADDR_W-1:0] acc_adr;
    logic [SEL_W-1:0]  acc_sel;
    logic              acc_we;
    logic [DATA_W-1:0] acc_dat;

    logic [SEL_W-1:0]  bank_we;
    logic              bank_re;

    // Byte-offset bits and aliased upper address bits are deliberately unused.
    logic adr_unused;
    assign adr_unused = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            adr_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
            dat_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                adr_q <= wb_adr_i[ADDR_W+1:2];
                sel_q <= wb_sel_i;
                we_q  <= wb_we_i;
                dat_q <= wb_dat_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                // No new acceptance while reset is being applied.
                if (wb_cyc_i && wb_stb_i && !rst) begin
                    accept  = 1'b1;
                    cnt_nxt = '0;
                    if (WAIT_STATES == 0) begin
                        state_nxt = ST_ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Abort beats completion if cyc drops in the last wait cycle.
                if (!wb_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == WS_LAST) begin
                    state_nxt = ST_ACK;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // live bus must feed the banks; otherwise the captured request does.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_adr = wb_adr_i[ADDR_W+1:2];
            acc_sel = wb_sel_i;
            acc_we  = wb_we_i;
            acc_dat = wb_dat_i;
        end else begin
            acc_adr = adr_q;
            acc_sel = sel_q;
            acc_we  = we_q;
            acc_dat = dat_q;
        end
    end

    assign bank_we  = (commit && acc_we) ? acc_sel : '0;
    assign bank_re  = commit && !acc_we;
    assign wb_ack_o = (state == ST_ACK);

    byte_bank #(.ADDR_W(ADDR_W)) bank0 (
        .clk  (clk),
        .rst  (rst),
        .we   (bank_we[LANE_B0]),
        .re   (bank_re),
        .addr (acc_adr),
        .din  (acc_dat[LANE_B0*BYTE_W +: BYTE_W]),
        .dout (wb_dat_o[LANE_B0*BYTE_W +: BYTE_W])
    );

    byte_bank #(.ADDR_W(ADDR_W)) bank1 (
        .clk  (clk),
        .rst  (rst),
        .we   (bank_we[LANE_B1]),
        .re   (bank_re),
        .addr (acc_adr),
        .din  (acc_dat[LANE_B1*BYTE_W +: BYTE_W]),
        .dout (wb_dat_o[LANE_B1*BYTE_W +: BYTE_W])
    );

    byte_bank #(.ADDR_W(ADDR_W)) bank2 (
        .clk  (clk),
        .rst  (rst),
        .we   (bank_we[LANE_B2]),
        .re   (bank_re),
        .addr (acc_adr),
        .din  (acc_dat[LANE_B2*BYTE_W +: BYTE_W]),
        .dout (wb_dat_o[LANE_B2*BYTE_W +: BYTE_W])
    );

    byte_bank #(.ADDR_W(ADDR_W)) bank3 (
        .clk  (clk),
        .rst  (rst),
        .we   (bank_we[LANE_B3]),
        .re   (bank_re),
        .addr (acc_adr),
        .din  (acc_dat[LANE_B3*BYTE_W +: BYTE_W]),
        .dout (wb_dat_o[LANE_B3*BYTE_W +: BYTE_W])
    );

endmodule

// File: tb/tb_wb_data_ram.sv
// Directed bench for wb_data_ram: one instance with one wait state, one with none.
// Both instances share the request inputs; each has its own outputs.
// Expected values are hand-computed constants.
module tb_wb_data_ram;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_o1, dat_o0;
    logic        ack1, ack0;

    int n_tests = 0;
    int n_fail  = 0;

    wb_data_ram #(.ADDR_W(10), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w),
        .wb_dat_o(dat_o1), .wb_ack_o(ack1)
    );

    wb_data_ram #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w),
        .wb_dat_o(dat_o0), .wb_ack_o(ack0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] peek(input logic [9:0] idx);
        return {dut.bank0.mem[idx], dut.bank1.mem[idx], dut.bank2.mem[idx], dut.bank3.mem[idx]};
    endfunction

    function automatic logic ack_of(input int which);
        return (which != 0) ? ack1 : ack0;
    endfunction

    function automatic logic [31:0] dat_of(input int which);
        return (which != 0) ? dat_o1 : dat_o0;
    endfunction

    // One transfer: request presented in cycle T (from a falling edge), lat is
    // the number of cycles after T at which ack was seen (-1 if never).
    task automatic xfer(input int which, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
        lat = -1;
        rd  = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack_of(which)) begin
                lat = n;
                rd  = dat_of(which);
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        seen;
    logic [6:0]  pattern;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; sel = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack1), 32'h0);
        chk("rst_dat", dat_o1, 32'h0);
        rst = 1'b0;

        // Byte writes into word 0, lanes 3 and 2.
        xfer(1, 1'b1, 32'h3, 4'b0001, 32'h0000_00FF, lat, rd);
        chk("wr_b3_lat", 32'(lat), 32'd2);
        chk("wr_b3_mem", peek(10'd0) & 32'h0000_00FF, 32'h0000_00FF);
        xfer(1, 1'b1, 32'h2, 4'b0010, 32'h0000_EE00, lat, rd);
        chk("wr_b2_mem", peek(10'd0) & 32'h0000_FFFF, 32'h0000_EEFF);

        // Lanes 0 and 1, then full-word read.
        xfer(1, 1'b1, 32'h0, 4'b1000, 32'hCC00_0000, lat, rd);
        xfer(1, 1'b1, 32'h1, 4'b0100, 32'h00DD_0000, lat, rd);
        xfer(1, 1'b0, 32'h0, 4'b0001, 32'h0, lat, rd);
        chk("rd0_lat", 32'(lat), 32'd2);
        chk("rd0_dat", rd, 32'hCCDD_EEFF);
        @(negedge clk);
        chk("rd0_ack_pulse", 32'(ack1), 32'h0);
        chk("rd0_hold", dat_o1, 32'hCCDD_EEFF);

        // Halfword writes and a no-lane write.
        xfer(1, 1'b1, 32'h4, 4'b1100, 32'hAABB_0000, lat, rd);
        xfer(1, 1'b1, 32'h4, 4'b0011, 32'h0000_8899, lat, rd);
        xfer(1, 1'b0, 32'h4, 4'b1111, 32'h0, lat, rd);
        chk("rd4_half", rd, 32'hAABB_8899);
        xfer(1, 1'b1, 32'h4, 4'b0000, 32'hFFFF_FFFF, lat, rd);
        chk("sel0_lat", 32'(lat), 32'd2);
        xfer(1, 1'b0, 32'h4, 4'b1111, 32'h0, lat, rd);
        chk("sel0_unchanged", rd, 32'hAABB_8899);

        // Upper address bits alias; byte offset bits ignored.
        xfer(1, 1'b0, 32'h0000_1003, 4'b1111, 32'h0, lat, rd);
        chk("alias_rd", rd, 32'hCCDD_EEFF);

        // Abort: cyc dropped in the wait cycle.
        xfer(1, 1'b1, 32'h8, 4'b1111, 32'h1122_3344, lat, rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; sel = 4'b1111; dat_w = 32'h4455_6677;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | ack1;
        end
        chk("abort_no_ack", 32'(seen), 32'h0);
        xfer(1, 1'b0, 32'h8, 4'b1111, 32'h0, lat, rd);
        chk("abort_old_val", rd, 32'h1122_3344);

        // Request changes after acceptance are ignored.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC; sel = 4'b1111; dat_w = 32'h1234_5678;
        @(negedge clk);
        we = 1'b0; adr = 32'h0; sel = 4'b0000; dat_w = 32'h0;
        @(negedge clk);
        chk("chg_ack", 32'(ack1), 32'h1);
        cyc = 1'b0; stb = 1'b0;
        xfer(1, 1'b0, 32'hC, 4'b1111, 32'h0, lat, rd);
        chk("chg_latched", rd, 32'h1234_5678);

        // Reset during a read's wait cycle.
        xfer(1, 1'b0, 32'h4, 4'b1111, 32'h0, lat, rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ack", 32'(ack1), 32'h0);
        chk("rstmid_dat", dat_o1, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | ack1;
        end
        chk("rstmid_no_ack", 32'(seen), 32'h0);
        xfer(1, 1'b0, 32'h0, 4'b1111, 32'h0, lat, rd);
        chk("rstmid_mem_kept", rd, 32'hCCDD_EEFF);

        // Zero wait states.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, lat, rd);
        chk("ws0_wr_lat", 32'(lat), 32'd1);
        xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, lat, rd);
        chk("ws0_rd_lat", 32'(lat), 32'd1);
        chk("ws0_rd_dat", rd, 32'hDEAD_BEEF);

        // stb held for 6 cycles: ack on every other cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'b1111;
        pattern = '0;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) @(negedge clk);
            pattern[i] = ack0;
            if (i == 5) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        chk("ws0_burst_acks", 32'(pattern), 32'h0000_002A);
        chk("ws0_burst_dat", dat_o0, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_data_ram.md
Name: wb_data_ram

Overview:
Wishbone-classic slave data memory for the openMIPS SOPC. It is the responder on the MEM-stage data bus that the CPU's load/store unit drives as initiator.
- Storage is four byte-wide banks, so sb/sh/sw/swl/swr byte-lane writes and lb/lh/lw/lwl/lwr word reads are served with configurable wait states.
- It replaces the zero-latency combinational data RAM when the bus is moved to Wishbone.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words (4 KiB default).
- WAIT_STATES, 1, extra cycles between request acceptance and ack (0..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high (rst==1 on a rising clk edge resets; `RstEnable` polarity).
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; request present.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address; bits [1:0] ignored, bits [ADDR_W+1:2] select word, upper bits ignored (aliasing).
- wb_sel_i  in  4  byte-lane enables, big-endian: sel[3]=data[31:24]=byte offset 0 … sel[0]=data[7:0]=offset 3.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer complete, single-cycle pulse.

Behaviour:
- Reset:
  - state=IDLE, wb_ack_o=0, wb_dat_o=0, wait counter=0.
  - Memory contents are NOT cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - Accept when cyc&stb=1. Latch adr word index, sel, we, dat_i in acceptance cycle T.
  - Go to WAIT if WAIT_STATES>0, else ACK.
- WAIT:
  - Counter counts WAIT_STATES cycles, then go to ACK.
  - If cyc=0 in any WAIT cycle: abort, return to IDLE, no write, no ack.
- ACK:
  - wb_ack_o=1 for exactly one cycle, in cycle T+1+WAIT_STATES. Then go to IDLE unconditionally.
- Write commit:
  - Latched lanes with sel bit=1 are written on the edge entering ACK, so the data is visible to any later read.
  - Lanes with sel=0 are unchanged. sel=4'b0000 write is still acked and changes nothing.
- Read:
  - wb_dat_o is loaded with the full 32-bit word (all lanes, sel ignored) on the edge entering ACK.
  - It is valid during the ack cycle and holds until the next read ack or reset.
  - Sign/zero extension and lwl/lwr merging stay in the CPU MEM stage.
- Back-to-back:
  - stb still high in the cycle after ack is treated as a new request.
  - Throughput is one transfer per WAIT_STATES+2 cycles.
- Request changes after acceptance (adr/dat/sel/we) are ignored until the next IDLE acceptance.
- rst during WAIT or ACK:
  - Next cycle: IDLE, ack=0.
  - A write not yet committed is dropped. A write committed on the same edge as rst is kept.
- cyc=0 with stb=1: no acceptance.

Decomposition:
- Package wb_data_ram_pkg:
  - state encoding localparams (IDLE/WAIT/ACK).
  - lane index constants (LANE_B0=3 … LANE_B3=0).
  - data/sel width defines consistent with `RegBus` from defines.v.
- Sub-module byte_bank:
  - single-port 2**ADDR_W x 8 synchronous RAM (we, addr, din, dout).
  - instanced four times as bank0..bank3.
  - keeps per-bank hierarchy (data_ram-style bankN[addr]) for bench memory dumps.

Test Plan:
- WAIT_STATES=1, reset, then write adr=0x3 sel=0001 dat=0x000000FF -> ack exactly at T+2; word0 = xxxxxxFF; then adr=0x2 sel=0010 dat=0x0000EE00 -> word0 = xxxxEEFF.
- Byte writes CC@0, DD@1 then read adr=0x0 -> dat_o=0xCCDDEEFF in ack cycle, held after ack falls.
- Halfword write adr=0x4 sel=1100 dat=0xAABB0000, then sel=0011 dat=0x00008899 -> read 0x4 = 0xAABB8899. Also a sel=0000 write leaves it unchanged and is acked.
- Abort: write 0x44556677 to 0x8 with cyc dropped in WAIT -> no ack, next read of 0x8 returns old value.
- Reset mid-op: rst asserted in WAIT -> ack never pulses, dat_o=0, memory at 0x0 still 0xCCDDEEFF.
- WAIT_STATES=0 with stb held high for 6 cycles -> ack pulses at cycles 1,3,5 (one per 2 cycles), never two consecutive.
